// File: rtl/wam_pkg.sv
// Shared types and segment patterns for the whack-a-mole display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package wam_pkg;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } wam_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/wam_disp_if.sv
// Bundle between game core / board pins and the display driver.
// master = game side, slave = display driver.
interface wam_disp_if;
    logic [11:0] score;
    logic        pause;
    logic [7:0]  holes;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [7:0]  led;

    modport master (
        output score, pause, holes,
        input  an, seg, led
    );

    modport slave (
        input  score, pause, holes,
        output an, seg, led
    );
endinterface

// File: rtl/wam_bcd2seg.sv
// BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles show a dash; blank overrides everything.
module wam_bcd2seg
    import wam_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            unique case (nib)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/wam_disp.sv
// Multiplexed 4-digit score display with ghost-blanking guard,
// pause blink indicator and hole LED mirror.
module wam_disp
    import wam_pkg::*;
#(
    parameter int SCAN_DIV  = 17,
    parameter int GUARD     = 4,
    parameter int BLINK_DIV = 24
) (
    input logic       clk,
    input logic       clr,
    wam_disp_if.slave bus
);
    localparam logic [3:0] G_LAST = 4'(GUARD - 1);

    wam_state_e           state, state_n;
    logic [SCAN_DIV-1:0]  pre, pre_n;
    logic [3:0]           grd, grd_n;
    logic [1:0]           idx, idx_n;
    logic                 latch;
    logic [11:0]          score_q;
    logic [BLINK_DIV-1:0] blink;

    logic [3:0] nib;
    logic       blk;
    logic [6:0] bcd_seg;
    logic [6:0] dig_seg;
    logic [3:0] an_n;
    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic [7:0] led_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_SCAN;
            pre     <= '0;
            grd     <= '0;
            idx     <= '0;
            score_q <= '0;
            blink   <= '0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            grd   <= grd_n;
            idx   <= idx_n;
            blink <= blink + 1'b1;
            if (latch) score_q <= bus.score;
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = pre;
        grd_n   = grd;
        idx_n   = idx;
        latch   = 1'b0;
        unique case (state)
            ST_SCAN: begin
                pre_n = pre + 1'b1;
                if (pre == '1) begin
                    pre_n   = '0;
                    state_n = ST_BLANK;
                end
            end
            ST_BLANK: begin
                grd_n = grd + 1'b1;
                if (grd == G_LAST) begin
                    grd_n   = '0;
                    idx_n   = idx + 1'b1;
                    state_n = ST_SCAN;
                    // Frame boundary: take a fresh score so digits never tear.
                    latch   = (idx == 2'd3);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        nib = 4'd0;
        blk = 1'b1;
        unique case (idx)
            2'd0: begin
                nib = score_q[3:0];
                blk = 1'b0;
            end
            2'd1: begin
                nib = score_q[7:4];
                blk = (score_q[11:8] == 4'd0)
                   && (score_q[7:4] == 4'd0);
            end
            2'd2: begin
                nib = score_q[11:8];
                blk = (score_q[11:8] == 4'd0);
            end
            2'd3: begin
                nib = 4'd0;
                blk = 1'b1;
            end
            default: ;
        endcase
    end

    wam_bcd2seg u_bcd (
        .nib   (nib),
        .blank (blk),
        .seg   (bcd_seg)
    );

    always_comb begin
        dig_seg = bcd_seg;
        if (idx == 2'd3 && bus.pause) dig_seg = SEG_P;
        an_n = 4'hF;
        if (state == ST_SCAN) an_n = ~(4'b0001 << idx);
        if (bus.pause && blink[BLINK_DIV-1]) an_n = 4'hF;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            led_q <= 8'h00;
        end else begin
            an_q  <= an_n;
            if (state == ST_SCAN) seg_q <= dig_seg;
            led_q <= bus.pause ? 8'h00 : bus.holes;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.led = led_q;
endmodule

// File: tb/tb_wam_disp.sv
// Randomised self-checking bench for wam_disp with a frame-timing model.
// Small parameters so a full frame is 40 cycles and a blink period 64.
module tb_wam_disp;
    import wam_pkg::*;

    localparam int SD   = 3;
    localparam int GD   = 2;
    localparam int BD   = 6;
    localparam int LIT  = 1 << SD;
    localparam int SLOT = LIT + GD;
    localparam int FR   = 4 * SLOT;

    logic clk = 1'b0;
    logic clr = 1'b1;

    wam_disp_if bus ();

    wam_disp #(
        .SCAN_DIV  (SD),
        .GUARD     (GD),
        .BLINK_DIV (BD)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [6:0] enc(logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
        if (n > 4'd9) return SEG_DASH;
        return tbl[n];
    endfunction

    function automatic logic [6:0] digit(logic [11:0] s, logic p, int d);
        logic [3:0] h, t, o;
        h = s[11:8];
        t = s[7:4];
        o = s[3:0];
        case (d)
            0: return enc(o);
            1: return (h == 0 && t == 0) ? SEG_BLANK : enc(t);
            2: return (h == 0) ? SEG_BLANK : enc(h);
            default: return p ? SEG_P : SEG_BLANK;
        endcase
    endfunction

    // Model: time since reset release decides slot, phase and blink.
    int         mt   = 0;
    logic [11:0] msq = '0;
    logic [6:0]  mseg = 7'h7F;

    always @(posedge clk) begin
        int p, d;
        bit scan, bl;
        logic [3:0] ea;
        logic [7:0] el;
        if (clr) begin
            mt   = 0;
            msq  = '0;
            mseg = 7'h7F;
        end else begin
            p    = mt % FR;
            d    = p / SLOT;
            scan = (p % SLOT) < LIT;
            bl   = ((mt >> (BD - 1)) & 1) == 1;
            ea   = scan ? ~(4'b0001 << d) : 4'hF;
            if (bus.pause && bl) ea = 4'hF;
            if (scan) mseg = digit(msq, bus.pause, d);
            el = bus.pause ? 8'h00 : bus.holes;
            if (p == FR - 1) msq = bus.score;
            mt++;
            #1;
            check("an", bus.an, ea);
            if (ea != 4'hF) check("seg", bus.seg, mseg);
            check("led", bus.led, el);
        end
    end

    task automatic expect_digit(string nm, logic [3:0] a, logic [6:0] s);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.an == a) break;
        end
        if (bus.an == a) check(nm, bus.seg, s);
        else check({nm, "_timeout"}, bus.an, a);
    endtask

    task automatic frames(int n);
        repeat (n * FR) @(negedge clk);
    endtask

    initial begin
        int run, maxrun, nonf, lit, gap;
        bus.score = '0;
        bus.pause = 1'b0;
        bus.holes = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) clr = 1'b0;
        @(posedge clk) #1;
        check("first_an", bus.an, 4'b1110);
        check("first_seg", bus.seg, SEG_0);

        @(negedge clk) bus.score = 12'h042;
        frames(2);
        expect_digit("s042_d0", 4'b1110, SEG_2);
        expect_digit("s042_d1", 4'b1101, SEG_4);
        expect_digit("s042_d2", 4'b1011, SEG_BLANK);
        expect_digit("s042_d3", 4'b0111, SEG_BLANK);

        expect_digit("sync", 4'b1110, SEG_2);
        lit = 1;
        while (bus.an == 4'b1110 && lit < 50) begin
            @(negedge clk);
            if (bus.an == 4'b1110) lit++;
        end
        gap = 0;
        while (bus.an == 4'hF && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        check("lit_len", 12'(lit), 12'(LIT));
        check("gap_len", 12'(gap), 12'(GD));

        @(negedge clk) bus.score = 12'h005;
        frames(2);
        expect_digit("s005_d0", 4'b1110, SEG_5);
        expect_digit("s005_d1", 4'b1101, SEG_BLANK);
        expect_digit("s005_d2", 4'b1011, SEG_BLANK);

        @(negedge clk) bus.score = 12'h0A0;
        frames(2);
        expect_digit("s0a0_d0", 4'b1110, SEG_0);
        expect_digit("s0a0_d1", 4'b1101, SEG_DASH);
        expect_digit("s0a0_d2", 4'b1011, SEG_BLANK);

        @(negedge clk) bus.score = 12'h111;
        frames(2);
        expect_digit("s111_d1", 4'b1101, SEG_1);
        bus.score = 12'h999;
        expect_digit("tear_d2", 4'b1011, SEG_1);
        expect_digit("s999_d0", 4'b1110, SEG_9);
        expect_digit("s999_d1", 4'b1101, SEG_9);
        expect_digit("s999_d2", 4'b1011, SEG_9);

        @(negedge clk) begin
            bus.holes = 8'hA5;
            bus.pause = 1'b1;
        end
        @(posedge clk) #1;
        check("pause_led", bus.led, 8'h00);
        run = 0;
        maxrun = 0;
        nonf = 0;
        repeat (64) begin
            @(negedge clk);
            if (bus.an == 4'hF) run++;
            else begin
                run = 0;
                nonf++;
            end
            if (run > maxrun) maxrun = run;
        end
        check("blink_run", 12'(maxrun >= 32), 12'd1);
        check("blink_lit", 12'(nonf >= 24 && nonf <= 32), 12'd1);
        expect_digit("pause_p", 4'b0111, SEG_P);
        @(negedge clk) bus.pause = 1'b0;

        @(negedge clk) bus.holes = 8'hA5;
        @(posedge clk) #1;
        check("holes_a5", bus.led, 8'hA5);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.holes = 8'($urandom);
            if ($urandom_range(0, 29) == 0) bus.score = 12'($urandom);
            if ($urandom_range(0, 99) == 0) bus.pause = ~bus.pause;
        end

        @(negedge clk) begin
            bus.pause = 1'b0;
            bus.score = 12'h888;
            bus.holes = 8'hA5;
        end
        frames(2);
        for (int k = 0; k < 50; k++) begin
            if ((mt % SLOT) == LIT) break;
            @(negedge clk);
        end
        #2 clr = 1'b1;
        #1;
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_led", bus.led, 8'h00);
        @(posedge clk);
        @(negedge clk) clr = 1'b0;
        @(posedge clk) #1;
        check("rel_an", bus.an, 4'b1110);
        frames(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
